// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response channel plus the
// decode-side valid/ready instruction channel and the controller redirect inputs.
interface instr_fetch_if;
    // Instruction memory channel
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    // Decode channel
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [31:0] pc_plus4;
    // Controller redirect
    logic        pc_src;
    logic [31:0] pc_branch;
    logic        jump;

    // Fetch unit side
    modport master (
        output imem_req, imem_addr, instr_valid, instr, op, pc_plus4,
        input  imem_gnt, imem_rvalid, imem_rdata, instr_ready, pc_src, pc_branch, jump
    );

    // Memory / decode / controller side
    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, op, pc_plus4,
        output imem_gnt, imem_rvalid, imem_rdata, instr_ready, pc_src, pc_branch, jump
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch front end: issues word fetches under a credit limit, buffers
// in-order responses, hands them to decode, and redirects on jump/branch by
// flushing the buffer and discarding every response still in flight.
module instr_fetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input logic             clk,
    input logic             reset,
    instr_fetch_if.master   bus
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0] DepthW = (CW + 1)'(DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;   // PC of the next non-dropped response
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;

    logic [31:0] buf_instr [DEPTH];
    logic [31:0] buf_pc4   [DEPTH];

    logic        empty, pop, redirect, req, grant, push, rsp_ok;
    logic [31:0] instr_w, pc4_w, target;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Head of buffer drives decode; zeroed while empty so reset shows all-zero outputs
    always_comb begin
        empty    = (cnt_q == '0);
        instr_w  = empty ? 32'h0 : buf_instr[rd_q];
        pc4_w    = empty ? 32'h0 : buf_pc4[rd_q];
        pop      = !empty && bus.instr_ready;
        redirect = pop && (bus.jump || bus.pc_src);
        // Jump wins over branch; branch target is forced word aligned
        target   = bus.jump ? {pc4_w[31:28], instr_w[25:0], 2'b00}
                            : (bus.pc_branch & ~32'h3);
        req      = !reset && !redirect && (({1'b0, out_q} + {1'b0, cnt_q}) < DepthW);
        grant    = req && bus.imem_gnt;
        rsp_ok   = bus.imem_rvalid && (out_q != '0);
        push     = bus.imem_rvalid && (drop_q == '0) && !redirect;
    end

    assign bus.imem_req    = req;
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = !empty;
    assign bus.instr       = instr_w;
    assign bus.op          = instr_w[31:26];
    assign bus.pc_plus4    = pc4_w;

    // Next-state for PC, credit counters and buffer pointers
    always_comb begin
        pc_d      = pc_q;
        resp_pc_d = resp_pc_q;
        out_d     = out_q;
        drop_d    = drop_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        wr_d      = wr_q;

        if (grant) begin
            pc_d  = pc_q + 32'd4;
            out_d = out_d + CW'(1);
        end
        if (rsp_ok) begin
            out_d = out_d - CW'(1);
        end
        if (bus.imem_rvalid && drop_q != '0) begin
            drop_d = drop_q - CW'(1);
        end
        if (push) begin
            wr_d      = ptr_inc(wr_q);
            resp_pc_d = resp_pc_q + 32'd4;
        end
        if (pop) begin
            rd_d = ptr_inc(rd_q);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        // Every request still in flight after this cycle belongs to the old stream
        if (redirect) begin
            pc_d      = target;
            resp_pc_d = target;
            drop_d    = out_d;
            cnt_d     = '0;
            rd_d      = '0;
            wr_d      = '0;
        end
    end

    // Control state with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            out_q     <= '0;
            drop_q    <= '0;
            cnt_q     <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
        end else begin
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            out_q     <= out_d;
            drop_q    <= drop_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
        end
    end

    // Buffer storage; contents are only visible through cnt_q, so no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[wr_q] <= bus.imem_rdata;
            buf_pc4[wr_q]   <= resp_pc_q + 32'd4;
        end
    end

    // A response with nothing outstanding is a memory protocol violation
    assert property (@(posedge clk) disable iff (reset) bus.imem_rvalid |-> (out_q != '0));

endmodule
